// File: rtl/gate_bist_checker_if.sv
// -----------------------------------------------------------------------------
// gate_bist_checker_if
// Bundles the run request, gate stimulus/response and result signals of the
// gate library self-test checker.
//   start            : level-sampled run request (honoured only when idle)
//   drive_a/drive_b  : registered stimulus to gate inputs 1 and 2
//   resp[6:0]        : gate outputs {nor2,nand2,xnor2,xor2,or2,and2,inv1}
//   busy             : checker is running
//   done             : one-cycle end-of-run pulse
//   pass             : last completed run had no mismatches
//   err_mask[6:0]    : sticky per-gate mismatch flags for the current run
//   fail_count[3:0]  : failing vectors in the run, saturating at 15
//   first_fail_valid : a vector has failed in the current run
//   first_fail_vec   : {drive_a,drive_b} of the first failing vector
// slave  : the checker side.
// master : the controller / gate-under-test side.
// -----------------------------------------------------------------------------
interface gate_bist_checker_if;
  logic       start;
  logic       drive_a;
  logic       drive_b;
  logic [6:0] resp;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] err_mask;
  logic [3:0] fail_count;
  logic       first_fail_valid;
  logic [1:0] first_fail_vec;

  modport slave (
    input  start, resp,
    output drive_a, drive_b, busy, done, pass, err_mask, fail_count,
           first_fail_valid, first_fail_vec
  );

  modport master (
    output start, resp,
    input  drive_a, drive_b, busy, done, pass, err_mask, fail_count,
           first_fail_valid, first_fail_vec
  );
endinterface

// File: rtl/gate_bist_checker.sv
// -----------------------------------------------------------------------------
// gate_bist_checker
// Self-test sequencer and response checker for the two-input gate library.
// Steps {a,b} through 00,01,10,11 (LOOPS times), waits SETTLE_CYCLES after
// each drive change, then compares the seven gate outputs with the truth
// table. Reports a sticky per-gate error mask, a saturating failure count,
// the first failing vector and a pass flag. All outputs are registered.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : gate_bist_checker_if.slave (run request, stimulus, response,
//           results)
// Parameters:
//   SETTLE_CYCLES (>=1) : cycles between a drive change and its compare cycle
//   LOOPS (1..15)       : number of full passes over the four vectors
// -----------------------------------------------------------------------------
module gate_bist_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate_bist_checker_if.slave    bus
);

  localparam int               CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       LOOP_LAST = 4'(LOOPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_vec, w_vec_nxt;
  logic [3:0]       r_loop, w_loop_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_drive_a, w_drive_a_nxt;
  logic             r_drive_b, w_drive_b_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic [6:0]       r_err_mask, w_err_mask_nxt;
  logic [3:0]       r_fail_count, w_fail_count_nxt;
  logic             r_ffv, w_ffv_nxt;
  logic [1:0]       r_ffvec, w_ffvec_nxt;

  // Truth table for the vector currently on the drives.
  logic [6:0] w_expected;
  logic [6:0] w_miss;
  logic       w_vec_fail;
  logic       w_last;

  assign w_expected = {~(r_drive_a | r_drive_b),   // nor2
                       ~(r_drive_a & r_drive_b),   // nand2
                       ~(r_drive_a ^ r_drive_b),   // xnor2
                        (r_drive_a ^ r_drive_b),   // xor2
                        (r_drive_a | r_drive_b),   // or2
                        (r_drive_a & r_drive_b),   // and2
                       ~r_drive_a};                // inv1
  assign w_miss     = bus.resp ^ w_expected;
  assign w_vec_fail = |w_miss;
  assign w_last     = (r_vec == 2'd3) && (r_loop == LOOP_LAST);

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vec        <= '0;
      r_loop       <= '0;
      r_cnt        <= '0;
      r_drive_a    <= 1'b0;
      r_drive_b    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_mask   <= '0;
      r_fail_count <= '0;
      r_ffv        <= 1'b0;
      r_ffvec      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_vec        <= w_vec_nxt;
      r_loop       <= w_loop_nxt;
      r_cnt        <= w_cnt_nxt;
      r_drive_a    <= w_drive_a_nxt;
      r_drive_b    <= w_drive_b_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_err_mask   <= w_err_mask_nxt;
      r_fail_count <= w_fail_count_nxt;
      r_ffv        <= w_ffv_nxt;
      r_ffvec      <= w_ffvec_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case statement can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.start) w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_cnt == '0) w_state_nxt = S_CHECK;
      S_CHECK:  w_state_nxt = w_last ? S_DONE : S_SETTLE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_vec_nxt        = r_vec;
    w_loop_nxt       = r_loop;
    w_cnt_nxt        = r_cnt;
    w_drive_a_nxt    = r_drive_a;
    w_drive_b_nxt    = r_drive_b;
    w_done_nxt       = 1'b0;
    w_pass_nxt       = r_pass;
    w_err_mask_nxt   = r_err_mask;
    w_fail_count_nxt = r_fail_count;
    w_ffv_nxt        = r_ffv;
    w_ffvec_nxt      = r_ffvec;
    // Registered busy follows the state being entered.
    w_busy_nxt       = (w_state_nxt != S_IDLE);

    unique case (r_state)
      S_IDLE: begin
        w_drive_a_nxt = 1'b0;
        w_drive_b_nxt = 1'b0;
        if (bus.start) begin
          w_err_mask_nxt   = '0;
          w_fail_count_nxt = '0;
          w_ffv_nxt        = 1'b0;
          w_ffvec_nxt      = '0;
          w_pass_nxt       = 1'b0;
          w_vec_nxt        = 2'd0;
          w_loop_nxt       = 4'd0;
          w_cnt_nxt        = CNT_LOAD;
        end
      end

      S_SETTLE: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_ONE;
      end

      S_CHECK: begin
        w_err_mask_nxt = r_err_mask | w_miss;
        if (w_vec_fail) begin
          if (r_fail_count != 4'd15) w_fail_count_nxt = r_fail_count + 4'd1;
          if (!r_ffv) begin
            w_ffv_nxt   = 1'b1;
            w_ffvec_nxt = {r_drive_a, r_drive_b};
          end
        end
        if (w_last) begin
          w_done_nxt = 1'b1;
          // Include this final compare, since err_mask updates on the same edge.
          w_pass_nxt = ((r_err_mask | w_miss) == '0);
        end else begin
          w_vec_nxt     = r_vec + 2'd1;
          if (r_vec == 2'd3) w_loop_nxt = r_loop + 4'd1;
          w_drive_a_nxt = w_vec_nxt[1];
          w_drive_b_nxt = w_vec_nxt[0];
          w_cnt_nxt     = CNT_LOAD;
        end
      end

      S_DONE: begin
        // Drives return to 0 together with the move back to IDLE.
        w_drive_a_nxt = 1'b0;
        w_drive_b_nxt = 1'b0;
      end

      default: ;
    endcase
  end

  assign bus.drive_a          = r_drive_a;
  assign bus.drive_b          = r_drive_b;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.pass             = r_pass;
  assign bus.err_mask         = r_err_mask;
  assign bus.fail_count       = r_fail_count;
  assign bus.first_fail_valid = r_ffv;
  assign bus.first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_gate_bist_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_bist_checker
// Directed bench for gate_bist_checker. Three instances share clk/rst_n:
//   u0 : defaults, resp from a gate model with selectable faults
//   u1 : LOOPS=4, resp tied to 0
//   u2 : SETTLE_CYCLES=1, resp from a gate model with selectable faults
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_gate_bist_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_bist_checker_if bus0 ();
  gate_bist_checker_if bus1 ();
  gate_bist_checker_if bus2 ();

  gate_bist_checker u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  gate_bist_checker #(.SETTLE_CYCLES(2), .LOOPS(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  gate_bist_checker #(.SETTLE_CYCLES(1), .LOOPS(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;

  // Fault selection: 0 = golden, 1 = xor2 stuck at 0, 2 = inv1 acts as buffer.
  int fault0 = 0;
  int fault2 = 0;

  function automatic logic [6:0] gate_model(input logic a, input logic b, input int fault);
    logic [6:0] r;
    r = {~(a | b), ~(a & b), ~(a ^ b), a ^ b, a | b, a & b, ~a};
    if (fault == 1) r[3] = 1'b0;
    if (fault == 2) r[0] = a;
    return r;
  endfunction

  always_comb bus0.resp = gate_model(bus0.drive_a, bus0.drive_b, fault0);
  always_comb bus2.resp = gate_model(bus2.drive_a, bus2.drive_b, fault2);
  assign bus1.resp = 7'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic done_of(input int which);
    case (which)
      0:       return bus0.done;
      1:       return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  // Pulses start on one instance across one edge (edge 0 of its run).
  task automatic start_pulse(input int which);
    case (which)
      0:       bus0.start = 1'b1;
      1:       bus1.start = 1'b1;
      default: bus2.start = 1'b1;
    endcase
    tick();
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
  endtask

  // Ticks until done is seen; n = edge index, or -1 when the budget expires.
  task automatic wait_done(input int which, input int max, output int n);
    n = 0;
    while (!done_of(which) && n < max) begin
      tick();
      n++;
    end
    if (!done_of(which)) n = -1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    n_checks++;
    if ({bus0.drive_a, bus0.drive_b, bus0.busy, bus0.done, bus0.pass, bus0.err_mask,
         bus0.fail_count, bus0.first_fail_valid, bus0.first_fail_vec} !== 19'd0) begin
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b mask=%b cnt=%0d, expected all 0",
               bus0.busy, bus0.done, bus0.pass, bus0.err_mask, bus0.fail_count);
      n_fail++;
    end
  endtask

  task automatic test_golden();
    logic [1:0] exp_drv;
    fault0 = 0;
    start_pulse(0);
    n_checks++;
    if (bus0.busy !== 1'b1 || {bus0.drive_a, bus0.drive_b} !== 2'b00) begin
      $display("FAIL golden_edge0: busy=%b drv=%b%b, expected busy=1 drv=00",
               bus0.busy, bus0.drive_a, bus0.drive_b);
      n_fail++;
    end
    for (int e = 1; e <= 13; e++) begin
      tick();
      exp_drv = (e < 3) ? 2'b00 : (e < 6) ? 2'b01 : (e < 9) ? 2'b10 : 2'b11;
      if (e == 3 || e == 6 || e == 9) begin
        n_checks++;
        if ({bus0.drive_a, bus0.drive_b} !== exp_drv) begin
          $display("FAIL golden_drive_e%0d: got %b%b, expected %b", e,
                   bus0.drive_a, bus0.drive_b, exp_drv);
          n_fail++;
        end
      end
      if (e == 11) begin
        n_checks++;
        if (bus0.done !== 1'b0 || bus0.busy !== 1'b1) begin
          $display("FAIL golden_e11: done=%b busy=%b, expected done=0 busy=1", bus0.done, bus0.busy);
          n_fail++;
        end
      end
      if (e == 12) begin
        n_checks++;
        if ({bus0.done, bus0.pass, bus0.err_mask, bus0.fail_count, bus0.first_fail_valid}
            !== {1'b1, 1'b1, 7'd0, 4'd0, 1'b0}) begin
          $display("FAIL golden_done: done=%b pass=%b mask=%b cnt=%0d ffv=%b, expected 1 1 0000000 0 0",
                   bus0.done, bus0.pass, bus0.err_mask, bus0.fail_count, bus0.first_fail_valid);
          n_fail++;
        end
      end
      if (e == 13) begin
        n_checks++;
        if (bus0.done !== 1'b0 || bus0.busy !== 1'b0 || bus0.pass !== 1'b1) begin
          $display("FAIL golden_e13: done=%b busy=%b pass=%b, expected 0 0 1",
                   bus0.done, bus0.busy, bus0.pass);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_xor_stuck();
    int n;
    fault0 = 1;
    start_pulse(0);
    wait_done(0, 40, n);
    n_checks++;
    if (n !== 12) begin
      $display("FAIL xor_done_edge: got %0d, expected 12", n);
      n_fail++;
    end
    n_checks++;
    if ({bus0.pass, bus0.err_mask, bus0.fail_count, bus0.first_fail_valid, bus0.first_fail_vec}
        !== {1'b0, 7'b0001000, 4'd2, 1'b1, 2'b01}) begin
      $display("FAIL xor_results: pass=%b mask=%b cnt=%0d ffv=%b ffvec=%b, expected 0 0001000 2 1 01",
               bus0.pass, bus0.err_mask, bus0.fail_count, bus0.first_fail_valid, bus0.first_fail_vec);
      n_fail++;
    end
    tick();
    tick();
    n_checks++;
    if ({bus0.done, bus0.err_mask, bus0.fail_count} !== {1'b0, 7'b0001000, 4'd2}) begin
      $display("FAIL xor_hold: done=%b mask=%b cnt=%0d, expected 0 0001000 2",
               bus0.done, bus0.err_mask, bus0.fail_count);
      n_fail++;
    end
  endtask

  task automatic test_inv_buffer();
    int n;
    fault0 = 2;
    start_pulse(0);
    wait_done(0, 40, n);
    n_checks++;
    if (n !== 12 ||
        {bus0.pass, bus0.err_mask, bus0.fail_count, bus0.first_fail_valid, bus0.first_fail_vec}
        !== {1'b0, 7'b0000001, 4'd4, 1'b1, 2'b00}) begin
      $display("FAIL inv_results: edge=%0d pass=%b mask=%b cnt=%0d ffv=%b ffvec=%b, expected 12 0 0000001 4 1 00",
               n, bus0.pass, bus0.err_mask, bus0.fail_count, bus0.first_fail_valid, bus0.first_fail_vec);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_abort();
    int n;
    logic saw_done;
    fault0 = 1;
    start_pulse(0);            // edge 0
    for (int e = 1; e <= 4; e++) tick();
    bus0.start = 1'b1;
    tick();                    // edge 5, start must be ignored
    bus0.start = 1'b0;
    tick();                    // edge 6
    n_checks++;
    if ({bus0.drive_a, bus0.drive_b} !== 2'b10 || bus0.fail_count !== 4'd1 || bus0.busy !== 1'b1) begin
      $display("FAIL abort_e6: drv=%b%b cnt=%0d busy=%b, expected drv=10 cnt=1 busy=1",
               bus0.drive_a, bus0.drive_b, bus0.fail_count, bus0.busy);
      n_fail++;
    end
    tick();                    // edge 7
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus0.drive_a, bus0.drive_b, bus0.busy, bus0.done, bus0.pass, bus0.err_mask,
         bus0.fail_count, bus0.first_fail_valid, bus0.first_fail_vec} !== 19'd0) begin
      $display("FAIL abort_reset: busy=%b mask=%b cnt=%0d ffv=%b, expected all 0",
               bus0.busy, bus0.err_mask, bus0.fail_count, bus0.first_fail_valid);
      n_fail++;
    end
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_done |= bus0.done;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      saw_done |= bus0.done | bus0.busy;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      $display("FAIL abort_no_done: activity seen after reset=%b, expected 0", saw_done);
      n_fail++;
    end
    fault0 = 0;
    start_pulse(0);
    wait_done(0, 40, n);
    n_checks++;
    if (n !== 12 || bus0.pass !== 1'b1 || bus0.err_mask !== 7'd0) begin
      $display("FAIL abort_fresh_run: edge=%0d pass=%b mask=%b, expected 12 1 0000000",
               n, bus0.pass, bus0.err_mask);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_saturate();
    int n;
    start_pulse(1);
    wait_done(1, 100, n);
    n_checks++;
    if (n !== 48) begin
      $display("FAIL sat_done_edge: got %0d, expected 48", n);
      n_fail++;
    end
    n_checks++;
    if ({bus1.pass, bus1.err_mask, bus1.fail_count, bus1.first_fail_valid, bus1.first_fail_vec}
        !== {1'b0, 7'b1111111, 4'd15, 1'b1, 2'b00}) begin
      $display("FAIL sat_results: pass=%b mask=%b cnt=%0d ffv=%b ffvec=%b, expected 0 1111111 15 1 00",
               bus1.pass, bus1.err_mask, bus1.fail_count, bus1.first_fail_valid, bus1.first_fail_vec);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    fault2 = 1;
    bus2.start = 1'b1;         // held high through both runs
    tick();                    // edge 0
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 2 || e == 4 || e == 6) begin
        n_checks++;
        if ({bus2.drive_a, bus2.drive_b} !== 2'(e / 2)) begin
          $display("FAIL b2b_drive_e%0d: got %b%b, expected %b", e,
                   bus2.drive_a, bus2.drive_b, 2'(e / 2));
          n_fail++;
        end
      end
      if (e == 8) begin
        n_checks++;
        if ({bus2.done, bus2.pass, bus2.err_mask, bus2.fail_count} !== {1'b1, 1'b0, 7'b0001000, 4'd2}) begin
          $display("FAIL b2b_done1: done=%b pass=%b mask=%b cnt=%0d, expected 1 0 0001000 2",
                   bus2.done, bus2.pass, bus2.err_mask, bus2.fail_count);
          n_fail++;
        end
        fault2 = 0;
      end
      if (e == 9) begin
        n_checks++;
        if (bus2.busy !== 1'b0 || bus2.done !== 1'b0 || bus2.err_mask !== 7'b0001000) begin
          $display("FAIL b2b_idle: busy=%b done=%b mask=%b, expected 0 0 0001000",
                   bus2.busy, bus2.done, bus2.err_mask);
          n_fail++;
        end
      end
      if (e == 10) begin
        n_checks++;
        if ({bus2.busy, bus2.err_mask, bus2.fail_count, bus2.first_fail_valid, bus2.pass}
            !== {1'b1, 7'd0, 4'd0, 1'b0, 1'b0}) begin
          $display("FAIL b2b_restart: busy=%b mask=%b cnt=%0d ffv=%b pass=%b, expected 1 0 0 0 0",
                   bus2.busy, bus2.err_mask, bus2.fail_count, bus2.first_fail_valid, bus2.pass);
          n_fail++;
        end
      end
    end
    wait_done(2, 30, n);
    bus2.start = 1'b0;
    n_checks++;
    if (n !== 8 || bus2.pass !== 1'b1 || bus2.err_mask !== 7'd0) begin
      $display("FAIL b2b_run2: edge=%0d pass=%b mask=%b, expected 8 1 0000000",
               n, bus2.pass, bus2.err_mask);
      n_fail++;
    end
    tick();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_golden();
    test_xor_stuck();
    test_inv_buffer();
    test_abort();
    test_saturate();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected the run to end earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gate_bist_checker.md
# gate_bist_checker

Synthesizable self-test sequencer and response checker for the basic two-input gate library (inv1, and2, or2, xor2, xnor2, nand2, nor2). It drives the two gate inputs through all four input combinations, waits a programmable settle time, samples the seven gate outputs and compares them against the expected truth table. Results are a sticky per-gate error mask, a failure count and a pass flag. It lets the gate library be checked in-system, from a single start pulse, without a simulation bench.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: cycles between driving a vector and the compare cycle. Legal range is 1 or more.
- LOOPS, default 1: number of full passes over the four vectors. Legal range is 1 to 15.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: level-sampled run request. It is honoured only in IDLE.
- drive_a, out, 1: registered stimulus to gate input1.
- drive_b, out, 1: registered stimulus to gate input2.
- resp, in, 7: gate outputs. Bit 0 is inv1, then and2, or2, xor2, xnor2, nand2, and bit 6 is nor2.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse at the end of a run.
- pass, out, 1: high when the last completed run had no mismatches.
- err_mask, out, 7: sticky, one bit per gate that mismatched at least once in the current run.
- fail_count, out, 4: number of failing vectors in the run. It saturates at 15.
- first_fail_valid, out, 1: high once any vector has failed in the current run.
- first_fail_vec, out, 2: {drive_a, drive_b} of the first failing vector.

## Operation
- States:
  - IDLE: drives are 0. When start=1 is seen at a clock edge, clear err_mask, fail_count and first_fail_*, set pass=0, load vec=0, loop=0, drive {a,b}=vec, load cnt=SETTLE_CYCLES-1, and go to SETTLE.
  - SETTLE: if cnt is nonzero, decrement it. If cnt is 0, go to CHECK.
  - CHECK: on the exit edge, compare resp with the expected value for the current drives.
    - Expected values for a=drive_a, b=drive_b: inv1=~a, and2=a&b, or2=a|b, xor2=a^b, xnor2=~(a^b), nand2=~(a&b), nor2=~(a|b).
    - err_mask |= (resp XOR expected).
    - If the vector mismatched: fail_count increments, saturating at 15. If first_fail_valid=0, latch first_fail_vec={a,b} and set first_fail_valid=1.
    - If vec=3 and loop=LOOPS-1, go to DONE.
    - Otherwise vec increments; it wraps from 3 to 0 and loop increments on the wrap. Drives take the new vec, cnt=SETTLE_CYCLES-1, and the state returns to SETTLE.
  - DONE: done=1 and pass=(err_mask==0). Go to IDLE on the next edge.
- Vector order is {a,b} = 00, 01, 10, 11, repeated LOOPS times.
- start while busy is ignored. If start is held high, a new run begins from IDLE one cycle after DONE.
- pass, err_mask, fail_count and first_fail_* hold their values after DONE until the next accepted start.
- Reset, asserted at any time and including mid-run: all outputs are 0, the state is IDLE, and the internal vec, loop and cnt are 0. No done pulse is produced.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Each vector takes SETTLE_CYCLES+1 cycles. resp is sampled exactly SETTLE_CYCLES+1 edges after drive_a and drive_b change.
- Counting the start-accept edge as edge 0, the state enters DONE at edge N=4·LOOPS·(SETTLE_CYCLES+1). done is high for the cycle after edge N and low after edge N+1.
- With defaults, N=12: vector 00 is driven after edge 0, 01 after edge 3, 10 after edge 6 and 11 after edge 9.
- busy rises after edge 0 and falls after edge N+1.
- pass updates together with the rising edge of done.

## Test plan
- Golden gates, defaults, start pulsed for 1 cycle -> drives step 00, 01, 10, 11 every 3 cycles. done pulses after edge 12 with pass=1, err_mask=0, fail_count=0 and first_fail_valid=0.
- xor2 output (resp[3]) stuck at 0 -> err_mask=7'b0001000, fail_count=2, first_fail_vec=2'b01, pass=0.
- inv1 modelled as a buffer -> all four vectors fail. err_mask=7'b0000001, fail_count=4, first_fail_vec=2'b00.
- LOOPS=4 with resp tied to 0 -> 16 failing vectors. fail_count saturates at 15, err_mask=7'b1111111, done after edge 48.
- start pulsed again at edge 5 of a run, then rst_n pulled low at edge 7 -> the second start is ignored. After reset all outputs are 0 with no done. A fresh start then completes normally.
- SETTLE_CYCLES=1 with start held high -> a 2-cycle cadence per vector and done after edge 8. The second run begins at the edge after the return to IDLE, and the results are cleared at its start.
